// File: rtl/io_pkg.sv
// Shared constants for the core/UART buffering bridge.
// Default widths, depths and sticky error bit positions.
package io_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int SEND_DEPTH_DEF = 16;
  localparam int RECV_DEPTH_DEF = 16;

  localparam int ERR_RX_OVF = 0;
  localparam int ERR_CORE   = 1;

  localparam int ERR_W = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and first-word fall-through.
// Ports: push/pop/din in; dout, full, empty, count, drop_push/drop_pop out.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_push,
  output logic                   drop_pop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

  // Acceptance uses start-of-cycle full/empty only, so a
  // push into a full FIFO is dropped even alongside a pop.
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign drop_push = push && full;
  assign drop_pop  = pop && empty;

  // Head is forced to zero when empty so no stale or
  // uninitialised storage ever appears on the output.
  assign dout = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffers core<->UART byte streams with one FIFO per direction.
// Ports: core send/recv, uart send/recv, counts, sticky err_flags.
module uart_fifo_bridge
  import io_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SEND_DEPTH = SEND_DEPTH_DEF,
  parameter int RECV_DEPTH = RECV_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           core_send_data,
  input  logic                        core_send_push,
  output logic                        core_send_full,
  output logic [DATA_W-1:0]           core_recv_data,
  output logic                        core_recv_valid,
  input  logic                        core_recv_pop,
  output logic [DATA_W-1:0]           uart_send_data,
  output logic                        uart_send_ready,
  input  logic                        uart_send_valid,
  input  logic [DATA_W-1:0]           uart_recv_data,
  input  logic                        uart_recv_valid,
  output logic                        uart_recv_ready,
  output logic [$clog2(SEND_DEPTH):0] send_count,
  output logic [$clog2(RECV_DEPTH):0] recv_count,
  output logic [ERR_W-1:0]            err_flags
);

  logic send_empty;
  logic send_pop;
  logic send_drop_push;
  logic send_drop_pop;
  logic recv_full;
  logic recv_empty;
  logic recv_drop_push;
  logic recv_drop_pop;

  assign uart_send_ready = !send_empty;
  assign send_pop        = uart_send_ready && uart_send_valid;
  assign uart_recv_ready = !recv_full;
  assign core_recv_valid = !recv_empty;

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (SEND_DEPTH)
  ) u_send (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (core_send_push),
    .pop       (send_pop),
    .din       (core_send_data),
    .dout      (uart_send_data),
    .full      (core_send_full),
    .empty     (send_empty),
    .count     (send_count),
    .drop_push (send_drop_push),
    .drop_pop  (send_drop_pop)
  );

  // A valid byte offered while full is the overflow case:
  // ready is low so the UART loses it upstream.
  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (RECV_DEPTH)
  ) u_recv (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (uart_recv_valid),
    .pop       (core_recv_pop),
    .din       (uart_recv_data),
    .dout      (core_recv_data),
    .full      (recv_full),
    .empty     (recv_empty),
    .count     (recv_count),
    .drop_push (recv_drop_push),
    .drop_pop  (recv_drop_pop)
  );

  // send_drop_pop cannot assert (pop is gated by ready) but
  // folding it in keeps every FIFO status bit accounted for.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_flags <= '0;
    end else if (flush) begin
      err_flags <= '0;
    end else begin
      if (recv_drop_push)
        err_flags[ERR_RX_OVF] <= 1'b1;
      if (send_drop_push || recv_drop_pop || send_drop_pop)
        err_flags[ERR_CORE] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed self-checking bench for uart_fifo_bridge.
// One task per scenario; expected values are hand-computed.
module tb_uart_fifo_bridge;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic [7:0] core_send_data;
  logic       core_send_push;
  logic       core_send_full;
  logic [7:0] core_recv_data;
  logic       core_recv_valid;
  logic       core_recv_pop;
  logic [7:0] uart_send_data;
  logic       uart_send_ready;
  logic       uart_send_valid;
  logic [7:0] uart_recv_data;
  logic       uart_recv_valid;
  logic       uart_recv_ready;
  logic [4:0] send_count;
  logic [4:0] recv_count;
  logic [1:0] err_flags;

  int tests;
  int fails;

  uart_fifo_bridge #(
    .DATA_W     (8),
    .SEND_DEPTH (16),
    .RECV_DEPTH (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush           (flush),
    .core_send_data  (core_send_data),
    .core_send_push  (core_send_push),
    .core_send_full  (core_send_full),
    .core_recv_data  (core_recv_data),
    .core_recv_valid (core_recv_valid),
    .core_recv_pop   (core_recv_pop),
    .uart_send_data  (uart_send_data),
    .uart_send_ready (uart_send_ready),
    .uart_send_valid (uart_send_valid),
    .uart_recv_data  (uart_recv_data),
    .uart_recv_valid (uart_recv_valid),
    .uart_recv_ready (uart_recv_ready),
    .send_count      (send_count),
    .recv_count      (recv_count),
    .err_flags       (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    tests++; if (core_recv_valid !== 1'b0) begin fails++; $display("FAIL reset_recv_valid got %b exp 0", core_recv_valid); end
    tests++; if (uart_send_ready !== 1'b0) begin fails++; $display("FAIL reset_send_ready got %b exp 0", uart_send_ready); end
    tests++; if (uart_recv_ready !== 1'b1) begin fails++; $display("FAIL reset_recv_ready got %b exp 1", uart_recv_ready); end
    tests++; if (core_send_full !== 1'b0) begin fails++; $display("FAIL reset_send_full got %b exp 0", core_send_full); end
    tests++; if (send_count !== 5'd0) begin fails++; $display("FAIL reset_send_count got %0d exp 0", send_count); end
    tests++; if (recv_count !== 5'd0) begin fails++; $display("FAIL reset_recv_count got %0d exp 0", recv_count); end
    tests++; if (err_flags !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", err_flags); end
    tests++; if (uart_send_data !== 8'h00) begin fails++; $display("FAIL reset_send_data got %h exp 00", uart_send_data); end
    tests++; if (core_recv_data !== 8'h00) begin fails++; $display("FAIL reset_recv_data got %h exp 00", core_recv_data); end
  endtask

  task automatic test_send_order();
    logic [7:0] exp;
    core_send_push = 1'b1;
    core_send_data = 8'h41; tick();
    core_send_data = 8'h42; tick();
    core_send_data = 8'h43; tick();
    core_send_push = 1'b0;
    tests++; if (send_count !== 5'd3) begin fails++; $display("FAIL order_count3 got %0d exp 3", send_count); end
    tests++; if (uart_send_ready !== 1'b1) begin fails++; $display("FAIL order_ready got %b exp 1", uart_send_ready); end
    uart_send_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = 8'h41 + 8'(i);
      tests++; if (uart_send_data !== exp) begin fails++; $display("FAIL order_data%0d got %h exp %h", i, uart_send_data, exp); end
      tick();
      tests++; if (send_count !== 5'(2 - i)) begin fails++; $display("FAIL order_cnt%0d got %0d exp %0d", i, send_count, 2 - i); end
    end
    uart_send_valid = 1'b0;
    tests++; if (uart_send_ready !== 1'b0) begin fails++; $display("FAIL order_ready_drop got %b exp 0", uart_send_ready); end
  endtask

  task automatic test_send_full();
    core_send_push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      core_send_data = 8'(i);
      tick();
    end
    core_send_push = 1'b0;
    tests++; if (send_count !== 5'd16) begin fails++; $display("FAIL full_count got %0d exp 16", send_count); end
    tests++; if (core_send_full !== 1'b1) begin fails++; $display("FAIL full_flag got %b exp 1", core_send_full); end
    core_send_data  = 8'hFF;
    core_send_push  = 1'b1;
    uart_send_valid = 1'b1;
    tick();
    core_send_push  = 1'b0;
    uart_send_valid = 1'b0;
    tests++; if (err_flags !== 2'b10) begin fails++; $display("FAIL full_err got %b exp 10", err_flags); end
    tests++; if (send_count !== 5'd15) begin fails++; $display("FAIL full_count15 got %0d exp 15", send_count); end
    tests++; if (core_send_full !== 1'b0) begin fails++; $display("FAIL full_flag_clear got %b exp 0", core_send_full); end
    uart_send_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tests++; if (uart_send_data !== 8'(i)) begin fails++; $display("FAIL full_drain%0d got %h exp %h", i, uart_send_data, 8'(i)); end
      tick();
    end
    uart_send_valid = 1'b0;
    tests++; if (uart_send_ready !== 1'b0) begin fails++; $display("FAIL full_drained got %b exp 0", uart_send_ready); end
    do_flush();
  endtask

  task automatic test_recv_overflow();
    uart_recv_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_recv_data = 8'(i);
      tick();
    end
    tests++; if (recv_count !== 5'd16) begin fails++; $display("FAIL ovf_count got %0d exp 16", recv_count); end
    tests++; if (uart_recv_ready !== 1'b0) begin fails++; $display("FAIL ovf_ready got %b exp 0", uart_recv_ready); end
    tests++; if (err_flags !== 2'b00) begin fails++; $display("FAIL ovf_err_pre got %b exp 00", err_flags); end
    uart_recv_data = 8'd16;
    tick();
    uart_recv_valid = 1'b0;
    tests++; if (err_flags !== 2'b01) begin fails++; $display("FAIL ovf_err got %b exp 01", err_flags); end
    tests++; if (recv_count !== 5'd16) begin fails++; $display("FAIL ovf_count_hold got %0d exp 16", recv_count); end
    core_recv_pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++; if (core_recv_data !== 8'(i)) begin fails++; $display("FAIL ovf_pop%0d got %h exp %h", i, core_recv_data, 8'(i)); end
      tick();
    end
    tests++; if (core_recv_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b exp 0", core_recv_valid); end
    tick();
    core_recv_pop = 1'b0;
    tests++; if (err_flags !== 2'b11) begin fails++; $display("FAIL ovf_pop_empty_err got %b exp 11", err_flags); end
    tests++; if (recv_count !== 5'd0) begin fails++; $display("FAIL ovf_count0 got %0d exp 0", recv_count); end
    do_flush();
  endtask

  task automatic test_simul();
    uart_recv_data  = 8'h11;
    uart_recv_valid = 1'b1;
    tick();
    uart_recv_valid = 1'b0;
    tests++; if (core_recv_data !== 8'h11) begin fails++; $display("FAIL simul_head got %h exp 11", core_recv_data); end
    uart_recv_data  = 8'h55;
    uart_recv_valid = 1'b1;
    core_recv_pop   = 1'b1;
    tick();
    uart_recv_valid = 1'b0;
    core_recv_pop   = 1'b0;
    tests++; if (core_recv_data !== 8'h55) begin fails++; $display("FAIL simul_data got %h exp 55", core_recv_data); end
    tests++; if (recv_count !== 5'd1) begin fails++; $display("FAIL simul_count got %0d exp 1", recv_count); end
    tests++; if (core_recv_valid !== 1'b1) begin fails++; $display("FAIL simul_valid got %b exp 1", core_recv_valid); end
    core_recv_pop = 1'b1;
    tick();
    core_recv_pop = 1'b0;
    tests++; if (core_recv_valid !== 1'b0) begin fails++; $display("FAIL simul_empty got %b exp 0", core_recv_valid); end
    tests++; if (err_flags !== 2'b00) begin fails++; $display("FAIL simul_err got %b exp 00", err_flags); end
  endtask

  task automatic test_flush();
    core_recv_pop = 1'b1;
    tick();
    core_recv_pop   = 1'b0;
    core_send_push  = 1'b1;
    uart_recv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_send_data = 8'hA0 + 8'(i);
      uart_recv_data = 8'hB0 + 8'(i);
      tick();
    end
    tests++; if (send_count !== 5'd3) begin fails++; $display("FAIL flush_pre_send got %0d exp 3", send_count); end
    tests++; if (recv_count !== 5'd3) begin fails++; $display("FAIL flush_pre_recv got %0d exp 3", recv_count); end
    tests++; if (err_flags !== 2'b10) begin fails++; $display("FAIL flush_pre_err got %b exp 10", err_flags); end
    flush = 1'b1;
    tick();
    flush           = 1'b0;
    core_send_push  = 1'b0;
    uart_recv_valid = 1'b0;
    tests++; if (send_count !== 5'd0) begin fails++; $display("FAIL flush_send got %0d exp 0", send_count); end
    tests++; if (recv_count !== 5'd0) begin fails++; $display("FAIL flush_recv got %0d exp 0", recv_count); end
    tests++; if (err_flags !== 2'b00) begin fails++; $display("FAIL flush_err got %b exp 00", err_flags); end
    tests++; if (uart_send_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b exp 0", uart_send_ready); end
    tests++; if (core_recv_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", core_recv_valid); end
    tick();
    tests++; if (send_count !== 5'd0) begin fails++; $display("FAIL flush_after got %0d exp 0", send_count); end
  endtask

  task automatic test_async_reset();
    core_send_data = 8'h5A;
    core_send_push = 1'b1;
    core_recv_pop  = 1'b1;
    tick();
    core_recv_pop = 1'b0;
    tick();
    tests++; if (send_count !== 5'd2) begin fails++; $display("FAIL arst_pre_count got %0d exp 2", send_count); end
    tests++; if (err_flags !== 2'b10) begin fails++; $display("FAIL arst_pre_err got %b exp 10", err_flags); end
    #2 rstn = 1'b0;
    #1;
    tests++; if (send_count !== 5'd0) begin fails++; $display("FAIL arst_count got %0d exp 0", send_count); end
    tests++; if (uart_send_ready !== 1'b0) begin fails++; $display("FAIL arst_ready got %b exp 0", uart_send_ready); end
    tests++; if (err_flags !== 2'b00) begin fails++; $display("FAIL arst_err got %b exp 00", err_flags); end
    tests++; if (uart_send_data !== 8'h00) begin fails++; $display("FAIL arst_data got %h exp 00", uart_send_data); end
    tests++; if (uart_recv_ready !== 1'b1) begin fails++; $display("FAIL arst_recv_ready got %b exp 1", uart_recv_ready); end
    core_send_push = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    tests++; if (send_count !== 5'd0) begin fails++; $display("FAIL arst_after got %0d exp 0", send_count); end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rstn            = 1'b0;
    flush           = 1'b0;
    core_send_data  = '0;
    core_send_push  = 1'b0;
    core_recv_pop   = 1'b0;
    uart_send_valid = 1'b0;
    uart_recv_data  = '0;
    uart_recv_valid = 1'b0;
    test_reset();
    test_send_order();
    test_send_full();
    test_recv_overflow();
    test_simul();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
